cpu_exec_ctrl: RTL and testbench
================================

Name: cpu_exec_ctrl

Overview:
Execution controller for the single-cycle CPU. It produces the CPU clock-enable (cpu_en) and sequences run, halt, N-instruction step and PC breakpoint. It takes commands from the IO/debug side and provides status plus cycle and retired-instruction counters. The CPU's PC and register updates are gated by cpu_en, so each clock with cpu_en=1 retires exactly one instruction.

Parameters:
STEP_W, 16, width of the step-count field and of the internal step counter
CNT_W, 32, width of cycle_cnt and inst_cnt

Ports:
clock  input  1  system clock; all state updates on its rising edge
resetn  input  1  synchronous active-low reset, sampled on rising edge of clock
pc  input  32  current CPU PC (address of the instruction executing this cycle)
cmd_valid  input  1  command strobe
cmd_op  input  2  00 HALT, 01 RUN, 10 STEP, 11 SET_BP
cmd_data  input  32  SET_BP: bit0 = bp_en, [31:2] = bp word address; STEP: [STEP_W-1:0] = step count N
cmd_ready  output  1  command accepted this cycle when cmd_valid & cmd_ready
cpu_en  output  1  CPU advance enable (combinational from state, pc and bp regs)
halted  output  1  registered; 1 in HALTED or BP_HALT
bp_hit  output  1  registered sticky flag; set on breakpoint stop, cleared by RUN/STEP accept
cycle_cnt  output  CNT_W  clocks since reset with cpu_en=1 or 0 (free running)
inst_cnt  output  CNT_W  number of clocks with cpu_en=1 (retired instructions)

Behaviour:
- Reset (resetn=0 at an edge): state=HALTED, bp_en=0, bp_addr=0, step_cnt=0, skip_bp=0, bp_hit=0, halted=1, cycle_cnt=0, inst_cnt=0. Reset wins over any command in the same cycle and mid-step.
- States: HALTED, RUNNING, STEPPING, BP_HALT.
- cmd_ready: 1 in every state except STEPPING with step_cnt != 0. In that case HALT is still accepted (cmd_ready=1 when cmd_op=HALT), so a step burst can be aborted.
- bp_match = bp_en & (pc[31:2] == bp_addr). pc[1:0] is ignored.
- cpu_en = (state==RUNNING | state==STEPPING) & ~(bp_match & ~skip_bp).
- HALT accept: go to HALTED next cycle. cpu_en stays as computed in the accept cycle (no retroactive squash).
- RUN accept (from HALTED/BP_HALT): go to RUNNING, clear bp_hit, set skip_bp=1. skip_bp clears after the first clock with cpu_en=1. This lets execution resume past the breakpointed instruction.
- STEP accept with N: N=0 is a no-op (state unchanged, command consumed). N>0: go to STEPPING, step_cnt=N, clear bp_hit, set skip_bp=1.
- STEPPING: each clock with cpu_en=1 decrements step_cnt. When step_cnt==1 and cpu_en=1, the next state is HALTED. Exactly N instructions retire.
- RUNNING/STEPPING with bp_match & ~skip_bp: cpu_en=0 that cycle, next state BP_HALT, bp_hit=1. The instruction at bp_addr is not executed.
- SET_BP: accepted in any state where cmd_ready=1. It updates bp_en/bp_addr next cycle and does not change state. A new bp takes effect from the following cycle's compare.
- Commands received while already in the target state are accepted with no effect: RUN while RUNNING, HALT while HALTED. RUN/STEP during a step burst are held (cmd_ready=0) until the burst ends.
- halted is registered from the next state, so it equals 1 exactly while the state is HALTED/BP_HALT.
- Counters: cycle_cnt increments every non-reset clock. inst_cnt increments when cpu_en=1. Both wrap modulo 2^CNT_W with no saturation.
- Latency: command accept to first cpu_en=1 is 1 clock.

Test Plan:
- Reset, then idle 5 clocks -> halted=1, cpu_en=0, cycle_cnt=5, inst_cnt=0, cmd_ready=1.
- STEP N=3 with pc incrementing by 4 -> cpu_en high for exactly 3 clocks, then halted=1, inst_cnt=3. STEP N=0 -> no cpu_en pulse.
- SET_BP 0x00000011 (addr 0x10, en), then RUN from pc=0 -> cpu_en=1 for pc 0,4,8,C; cpu_en=0 at pc=0x10; bp_hit=1, halted=1, inst_cnt=4.
- After the bp stop, RUN -> pc=0x10 executes (skip_bp), bp_hit clears, running continues. Jumping back to 0x10 later -> stops again.
- STEP N=100, HALT after 10 retired -> halt accepted while cmd_ready held for RUN. inst_cnt=10 or 11 (accept cycle retires) and state HALTED. Then RUN during STEPPING -> cmd_ready=0.
- Drive resetn=0 mid-RUN with cmd_valid=1 RUN -> next cycle state HALTED, counters 0, bp_en=0. Separately, force inst_cnt to 2^32-1 and retire one -> wraps to 0.

Source files
------------

// File: rtl/cpu_exec_ctrl_if.sv
// cpu_exec_ctrl_if: command handshake, CPU pc/enable and status bundle for the execution controller
interface cpu_exec_ctrl_if #(parameter int CNT_W = 32);
    logic             cmd_valid;
    logic [1:0]       cmd_op;
    logic [31:0]      cmd_data;
    logic             cmd_ready;
    logic [31:0]      pc;
    logic             cpu_en;
    logic             halted;
    logic             bp_hit;
    logic [CNT_W-1:0] cycle_cnt;
    logic [CNT_W-1:0] inst_cnt;
    modport master (
        output cmd_valid, cmd_op, cmd_data, pc,
        input  cmd_ready, cpu_en, halted, bp_hit, cycle_cnt, inst_cnt
    );
    modport slave (
        input  cmd_valid, cmd_op, cmd_data, pc,
        output cmd_ready, cpu_en, halted, bp_hit, cycle_cnt, inst_cnt
    );
endinterface

// File: rtl/cpu_exec_ctrl.sv
// cpu_exec_ctrl: run/halt/step/breakpoint sequencing of the CPU clock-enable with cycle and retired-instruction counters
module cpu_exec_ctrl #(
    parameter int STEP_W = 16,
    parameter int CNT_W  = 32
) (
    input logic            clock,
    input logic            resetn,
    cpu_exec_ctrl_if.slave bus
);
    typedef enum logic [1:0] {HALTED, RUNNING, STEPPING, BP_HALT} state_t;
    localparam logic [1:0] OP_HALT = 2'b00;
    localparam logic [1:0] OP_RUN  = 2'b01;
    localparam logic [1:0] OP_STEP = 2'b10;
    localparam logic [1:0] OP_BP   = 2'b11;
    state_t            state_q, state_d;
    logic              bp_en_q, bp_en_d;
    logic [29:0]       bp_addr_q, bp_addr_d;
    logic [STEP_W-1:0] step_cnt_q, step_cnt_d, step_n;
    logic              skip_bp_q, skip_bp_d;
    logic              bp_hit_q, bp_hit_d;
    logic              halted_q, halted_d;
    logic [CNT_W-1:0]  cycle_cnt_q, cycle_cnt_d, inst_cnt_q, inst_cnt_d;
    logic              active, bp_stop, cpu_en, cmd_ready, acc;
    always_comb begin
        step_n      = bus.cmd_data[STEP_W-1:0];
        active      = state_q == RUNNING || state_q == STEPPING;
        bp_stop     = active && bp_en_q && bus.pc[31:2] == bp_addr_q && !skip_bp_q;
        cpu_en      = active && !bp_stop;
        cmd_ready   = !(state_q == STEPPING && step_cnt_q != '0) || bus.cmd_op == OP_HALT;
        acc         = bus.cmd_valid && cmd_ready;
        state_d     = state_q;
        bp_en_d     = bp_en_q;
        bp_addr_d   = bp_addr_q;
        step_cnt_d  = step_cnt_q;
        skip_bp_d   = cpu_en ? 1'b0 : skip_bp_q;
        bp_hit_d    = bp_hit_q;
        cycle_cnt_d = cycle_cnt_q + CNT_W'(1);
        inst_cnt_d  = inst_cnt_q + CNT_W'(cpu_en);
        if (cpu_en && state_q == STEPPING) begin
            step_cnt_d = step_cnt_q - STEP_W'(1);
            state_d    = step_cnt_q == STEP_W'(1) ? HALTED : STEPPING;
        end
        if (bp_stop) begin
            state_d  = BP_HALT;
            bp_hit_d = 1'b1;
        end
        // a breakpoint stop in the same cycle as HALT keeps the BP_HALT record
        if (acc && bus.cmd_op == OP_HALT && !bp_stop)
            state_d = HALTED;
        if (acc && bus.cmd_op == OP_RUN && !active) begin
            state_d   = RUNNING;
            bp_hit_d  = 1'b0;
            skip_bp_d = 1'b1;
        end
        if (acc && bus.cmd_op == OP_STEP && step_n != '0) begin
            state_d    = STEPPING;
            step_cnt_d = step_n;
            bp_hit_d   = 1'b0;
            skip_bp_d  = 1'b1;
        end
        if (acc && bus.cmd_op == OP_BP) begin
            bp_en_d   = bus.cmd_data[0];
            bp_addr_d = bus.cmd_data[31:2];
        end
        halted_d = state_d == HALTED || state_d == BP_HALT;
    end
    always_ff @(posedge clock) begin
        if (!resetn) begin
            state_q     <= HALTED;
            bp_en_q     <= 1'b0;
            bp_addr_q   <= '0;
            step_cnt_q  <= '0;
            skip_bp_q   <= 1'b0;
            bp_hit_q    <= 1'b0;
            halted_q    <= 1'b1;
            cycle_cnt_q <= '0;
            inst_cnt_q  <= '0;
        end else begin
            state_q     <= state_d;
            bp_en_q     <= bp_en_d;
            bp_addr_q   <= bp_addr_d;
            step_cnt_q  <= step_cnt_d;
            skip_bp_q   <= skip_bp_d;
            bp_hit_q    <= bp_hit_d;
            halted_q    <= halted_d;
            cycle_cnt_q <= cycle_cnt_d;
            inst_cnt_q  <= inst_cnt_d;
        end
    end
    assign bus.cpu_en    = cpu_en;
    assign bus.cmd_ready = cmd_ready;
    assign bus.halted    = halted_q;
    assign bus.bp_hit    = bp_hit_q;
    assign bus.cycle_cnt = cycle_cnt_q;
    assign bus.inst_cnt  = inst_cnt_q;
endmodule

// File: tb/tb_cpu_exec_ctrl.sv
// tb_cpu_exec_ctrl: directed plan plus random commands against a behavioural controller model
module tb_cpu_exec_ctrl;
    localparam logic [1:0] HALT = 2'b00, RUN = 2'b01, STEP = 2'b10, SETBP = 2'b11;
    logic clock = 1'b0;
    logic resetn = 1'b0;
    always #5 clock = ~clock;
    cpu_exec_ctrl_if #(.CNT_W(32)) bus ();
    cpu_exec_ctrl_if #(.CNT_W(3))  bus_s ();
    cpu_exec_ctrl #(.STEP_W(16), .CNT_W(32)) dut   (.clock(clock), .resetn(resetn), .bus(bus));
    cpu_exec_ctrl #(.STEP_W(16), .CNT_W(3))  dut_s (.clock(clock), .resetn(resetn), .bus(bus_s));
    assign bus_s.cmd_valid = bus.cmd_valid;
    assign bus_s.cmd_op    = bus.cmd_op;
    assign bus_s.cmd_data  = bus.cmd_data;
    assign bus_s.pc        = bus.pc;
    int n_chk = 0, n_err = 0;
    // model: mode 0 stopped, 1 free-running, 2 counting down a step burst
    int          mode = 0, rem = 0;
    bit          m_bp_en = 0, m_skip = 0, m_hit = 0;
    logic [29:0] m_bpw = '0;
    logic [31:0] m_cyc = '0, m_inst = '0;
    logic [31:0] cur_pc = '0;
    logic        obs_rdy, obs_en;
    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask
    task automatic cyc(input logic rn, input logic v, input logic [1:0] op, input logic [31:0] d);
        bit exp_en, exp_rdy, stop, was_idle;
        @(negedge clock);
        resetn        = rn;
        bus.cmd_valid = v;
        bus.cmd_op    = op;
        bus.cmd_data  = d;
        bus.pc        = cur_pc;
        #1;
        exp_en  = mode != 0 && !(m_bp_en && cur_pc[31:2] == m_bpw && !m_skip);
        exp_rdy = !(mode == 2 && rem != 0) || op == HALT;
        obs_en  = bus.cpu_en;
        obs_rdy = bus.cmd_ready;
        chk("cpu_en", {31'b0, bus.cpu_en}, {31'b0, exp_en});
        chk("cmd_ready", {31'b0, bus.cmd_ready}, {31'b0, exp_rdy});
        chk("halted", {31'b0, bus.halted}, {31'b0, mode == 0});
        chk("bp_hit", {31'b0, bus.bp_hit}, {31'b0, m_hit});
        chk("cycle_cnt", bus.cycle_cnt, m_cyc);
        chk("inst_cnt", bus.inst_cnt, m_inst);
        chk("cycle_cnt_w3", {29'b0, bus_s.cycle_cnt}, m_cyc % 8);
        chk("inst_cnt_w3", {29'b0, bus_s.inst_cnt}, m_inst % 8);
        @(posedge clock);
        if (!rn) begin
            mode = 0; rem = 0; m_bp_en = 0; m_bpw = '0; m_skip = 0; m_hit = 0;
            m_cyc = '0; m_inst = '0;
        end else begin
            was_idle = mode == 0;
            stop     = mode != 0 && !exp_en;
            m_cyc++;
            if (exp_en) begin
                m_inst++;
                m_skip = 0;
                cur_pc += 4;
                if (mode == 2) begin
                    rem--;
                    if (rem == 0) mode = 0;
                end
            end
            if (stop) begin
                mode = 0;
                m_hit = 1;
            end
            if (v && exp_rdy) begin
                if (op == HALT && !stop) mode = 0;
                if (op == RUN && was_idle) begin
                    mode = 1; m_hit = 0; m_skip = 1;
                end
                if (op == STEP && d[15:0] != 0) begin
                    mode = 2; rem = int'(d[15:0]); m_hit = 0; m_skip = 1;
                end
                if (op == SETBP) begin
                    m_bp_en = d[0];
                    m_bpw   = d[31:2];
                end
            end
        end
    endtask
    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cyc(1'b1, 1'b0, HALT, 32'h0);
    endtask
    initial begin
        bus.cmd_valid = 1'b0;
        bus.cmd_op    = HALT;
        bus.cmd_data  = '0;
        bus.pc        = '0;
        repeat (2) @(posedge clock);
        idle(5);
        #1;
        chk("idle5_cycle", bus.cycle_cnt, 32'd5);
        chk("idle5_halted", {31'b0, bus.halted}, 32'd1);
        cur_pc = 32'h0;
        cyc(1'b1, 1'b1, STEP, 32'd3);
        idle(5);
        #1;
        chk("step3_inst", bus.inst_cnt, 32'd3);
        chk("step3_pc", cur_pc, 32'h0c);
        cyc(1'b1, 1'b1, STEP, 32'd0);
        idle(3);
        #1;
        chk("step0_inst", bus.inst_cnt, 32'd3);
        cyc(1'b1, 1'b1, SETBP, 32'h11);
        cur_pc = 32'h0;
        cyc(1'b1, 1'b1, RUN, 32'h0);
        idle(6);
        #1;
        chk("bp_inst", bus.inst_cnt, 32'd7);
        chk("bp_hit", {31'b0, bus.bp_hit}, 32'd1);
        chk("bp_halted", {31'b0, bus.halted}, 32'd1);
        chk("bp_pc", cur_pc, 32'h10);
        cyc(1'b1, 1'b1, RUN, 32'h0);
        idle(3);
        #1;
        chk("resume_inst", bus.inst_cnt, 32'd10);
        chk("resume_hit_clr", {31'b0, bus.bp_hit}, 32'd0);
        cur_pc = 32'h13;
        idle(2);
        #1;
        chk("rehit", {31'b0, bus.bp_hit}, 32'd1);
        chk("rehit_inst", bus.inst_cnt, 32'd10);
        cur_pc = 32'h20;
        cyc(1'b1, 1'b1, STEP, 32'd100);
        cyc(1'b1, 1'b1, RUN, 32'h0);
        chk("run_held", {31'b0, obs_rdy}, 32'd0);
        idle(8);
        cyc(1'b1, 1'b1, HALT, 32'h0);
        chk("halt_accept", {31'b0, obs_rdy}, 32'd1);
        #1;
        chk("abort_inst", bus.inst_cnt, 32'd20);
        chk("abort_halted", {31'b0, bus.halted}, 32'd1);
        cur_pc = 32'h0;
        cyc(1'b1, 1'b1, RUN, 32'h0);
        idle(2);
        cyc(1'b0, 1'b1, RUN, 32'h0);
        #1;
        chk("rst_halted", {31'b0, bus.halted}, 32'd1);
        chk("rst_cycle", bus.cycle_cnt, 32'd0);
        chk("rst_inst", bus.inst_cnt, 32'd0);
        cur_pc = 32'h10;
        cyc(1'b1, 1'b1, RUN, 32'h0);
        idle(3);
        #1;
        chk("rst_bp_off", {31'b0, bus.bp_hit}, 32'd0);
        chk("rst_bp_inst", bus.inst_cnt, 32'd3);
        for (int i = 0; i < 800; i++) begin
            logic [1:0]  op;
            logic [31:0] d;
            if ($urandom_range(0, 7) == 0)
                cur_pc = ($urandom_range(0, 15) << 2) | $urandom_range(0, 3);
            op = 2'($urandom_range(0, 3));
            d  = 32'($urandom);
            if (op == STEP)
                d = $urandom_range(0, 15) == 0 ? 32'd200 : 32'($urandom_range(0, 6));
            if (op == SETBP)
                d = ($urandom_range(0, 15) << 2) | ($urandom_range(0, 1) << 1) | $urandom_range(0, 3) % 2;
            cyc($urandom_range(0, 149) != 0, $urandom_range(0, 3) == 0, op, d);
        end
        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end
endmodule
